// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered occupancy flags; level disambiguates full/empty
// because the pointers wrap modulo DEPTH.
module uart_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok_c;
  logic             pop_ok_c;
  logic [LW-1:0]    level_nxt_c;

  // Flags are registered, so a push into an empty FIFO cannot be popped the same cycle
  assign push_ok_c = push && !full;
  assign pop_ok_c  = pop && !empty;
  assign dout      = mem[rd_ptr];

  always_comb begin
    level_nxt_c = level;
    case ({push_ok_c, pop_ok_c})
      2'b10:   level_nxt_c = level + LW'(1);
      2'b01:   level_nxt_c = level - LW'(1);
      default: level_nxt_c = level;
    endcase
  end

  // Storage needs no reset; pointers and level define validity
  always_ff @(posedge clk) begin
    if (push_ok_c) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok_c)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt_c;
      full  <= (level_nxt_c == LW'(DEPTH));
      empty <= (level_nxt_c == '0);
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// 8N1 UART transmitter: FIFO-buffered bytes serialised LSB first onto txd,
// with the baud divisor latched per frame.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DIV_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [UART_DATA_BITS-1:0]   wr_data,
  input  logic                        tx_en,
  input  logic [DIV_W-1:0]            baud_div,
  output logic                        txd,
  output logic                        busy,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        overflow
);

  uart_tx_state_e              state;
  logic [UART_DATA_BITS-1:0]   shift;
  logic [2:0]                  bit_idx;
  logic [DIV_W-1:0]            baud_cnt;
  logic [DIV_W-1:0]            div_q;
  logic [UART_DATA_BITS-1:0]   fifo_dout;
  logic                        bit_done_c;
  logic                        fifo_pop_c;

  uart_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (fifo_pop_c),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bit_done_c = (baud_cnt == div_q);

  // A new frame starts from IDLE, or straight out of a finished stop bit
  assign fifo_pop_c = tx_en && !empty &&
                      ((state == IDLE) || ((state == STOP) && bit_done_c));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      txd      <= 1'b1;
      busy     <= 1'b0;
      shift    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
      div_q    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;

      if (state != IDLE) begin
        baud_cnt <= bit_done_c ? '0 : baud_cnt + DIV_W'(1);
      end

      case (state)
        IDLE: begin
          txd  <= 1'b1;
          busy <= 1'b0;
        end
        START: begin
          if (bit_done_c) begin
            state   <= DATA;
            bit_idx <= '0;
            txd     <= shift[0];
          end
        end
        DATA: begin
          if (bit_done_c) begin
            shift <= shift >> 1;
            if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'(1);
              txd     <= shift[1];
            end
          end
        end
        STOP: begin
          if (bit_done_c) begin
            state <= IDLE;
            txd   <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase

      // Frame load overrides the STOP->IDLE transition for back-to-back frames
      if (fifo_pop_c) begin
        state    <= START;
        shift    <= fifo_dout;
        div_q    <= baud_div;
        baud_cnt <= '0;
        bit_idx  <= '0;
        txd      <= 1'b0;
        busy     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed self-checking bench for uart_tx_engine: table of single frames plus
// hand-written multi-frame, overflow, baud-change, disable and reset sequences.
module tb_uart_tx_engine;
  import uart_pkg::*;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        tx_en;
  logic [15:0] baud_div;
  logic        txd;
  logic        busy;
  logic        full;
  logic        empty;
  logic [3:0]  level;
  logic        overflow;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [15:0] div;
    logic [7:0]  data;
    logic [9:0]  bits;  // bits[i] = txd level during bit period i
  } vec_t;

  vec_t vecs [5];

  uart_tx_engine #(
    .DEPTH (8),
    .DIV_W (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .tx_en    (tx_en),
    .baud_div (baud_div),
    .txd      (txd),
    .busy     (busy),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // Called at the negedge just after a START-entry edge; walks all 10 bit periods
  task automatic check_frame(input logic [9:0] bits, input int div, input string tag);
    for (int i = 0; i < UART_FRAME_BITS; i++) begin
      int bad;
      bad = 0;
      for (int c = 0; c <= div; c++) begin
        if (txd !== bits[i] || busy !== 1'b1) bad++;
        @(negedge clk);
      end
      check($sformatf("%s bit%0d bad_cycles", tag, i), 32'(bad), 32'd0);
    end
  endtask

  task automatic hold_idle(input int n, input string tag);
    int bad;
    bad = 0;
    for (int c = 0; c < n; c++) begin
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    check($sformatf("%s idle bad_cycles", tag), 32'(bad), 32'd0);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    tx_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{div: 16'd3, data: 8'hA5, bits: 10'b1101001010};
    vecs[1] = '{div: 16'd0, data: 8'h00, bits: 10'b1000000000};
    vecs[2] = '{div: 16'd1, data: 8'hFF, bits: 10'b1111111110};
    vecs[3] = '{div: 16'd2, data: 8'h3C, bits: 10'b1001111000};
    vecs[4] = '{div: 16'd0, data: 8'h81, bits: 10'b1100000010};

    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    tx_en    = 1'b0;
    baud_div = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset txd",      32'(txd),      32'd1);
    check("reset busy",     32'(busy),     32'd0);
    check("reset empty",    32'(empty),    32'd1);
    check("reset full",     32'(full),     32'd0);
    check("reset level",    32'(level),    32'd0);
    check("reset overflow", 32'(overflow), 32'd0);

    // Single-frame table: write, one-cycle latency to pop, frame, back to idle
    for (int v = 0; v < 5; v++) begin
      baud_div = vecs[v].div;
      tx_en    = 1'b1;
      wr_data  = vecs[v].data;
      wr_en    = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      check($sformatf("vec%0d empty after push", v), 32'(empty), 32'd0);
      check($sformatf("vec%0d txd before pop", v),   32'(txd),   32'd1);
      check($sformatf("vec%0d busy before pop", v),  32'(busy),  32'd0);
      @(negedge clk);
      check_frame(vecs[v].bits, int'(vecs[v].div), $sformatf("vec%0d", v));
      check($sformatf("vec%0d busy after frame", v), 32'(busy), 32'd0);
      check($sformatf("vec%0d txd after frame", v),  32'(txd),  32'd1);
      check($sformatf("vec%0d empty after frame", v), 32'(empty), 32'd1);
    end

    // Three consecutive writes at 1 clock/bit: 30 contiguous bit periods
    baud_div = 16'd0;
    tx_en    = 1'b1;
    wr_data  = 8'h01;
    wr_en    = 1'b1;
    @(negedge clk);
    wr_data = 8'h02;
    @(negedge clk);
    wr_data = 8'h03;
    fork
      begin
        check_frame({1'b1, 8'h01, 1'b0}, 0, "b2b f1");
        check_frame({1'b1, 8'h02, 1'b0}, 0, "b2b f2");
        check("b2b empty after third pop", 32'(empty), 32'd1);
        check_frame({1'b1, 8'h03, 1'b0}, 0, "b2b f3");
      end
      begin
        @(negedge clk);
        wr_en = 1'b0;
      end
    join
    check("b2b busy after", 32'(busy), 32'd0);

    // Fill with transmitter disabled; 9th write overflows
    tx_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("fill%0d level", i),    32'(level),    32'(i));
      check($sformatf("fill%0d full", i),     32'(full),     32'(i == 8));
      check($sformatf("fill%0d overflow", i), 32'(overflow), 32'd0);
      wr_data = 8'h10 + 8'(i);
      wr_en   = 1'b1;
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("ovf pulse",      32'(overflow), 32'd1);
    check("ovf level",      32'(level),    32'd8);
    check("ovf full",       32'(full),     32'd1);
    @(negedge clk);
    check("ovf pulse end",  32'(overflow), 32'd0);
    check("ovf level kept", 32'(level),    32'd8);
    tx_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      check_frame({1'b1, 8'h10 + 8'(i), 1'b0}, 0, $sformatf("drain%0d", i));
    end
    check("drain empty", 32'(empty), 32'd1);
    check("drain level", 32'(level), 32'd0);
    hold_idle(12, "drain");

    // Baud divisor change mid-DATA only affects the next frame
    baud_div = 16'd5;
    tx_en    = 1'b1;
    wr_data  = 8'h5A;
    wr_en    = 1'b1;
    @(negedge clk);
    wr_data = 8'hC3;
    @(negedge clk);
    wr_en = 1'b0;
    fork
      begin
        check_frame({1'b1, 8'h5A, 1'b0}, 5, "div f1");
        check_frame({1'b1, 8'hC3, 1'b0}, 1, "div f2");
      end
      begin
        repeat (18) @(negedge clk);
        baud_div = 16'd1;
      end
    join
    check("div busy after", 32'(busy), 32'd0);

    // tx_en dropped mid-frame: frame completes, two bytes remain queued
    baud_div = 16'd1;
    tx_en    = 1'b1;
    wr_data  = 8'h11;
    wr_en    = 1'b1;
    @(negedge clk);
    wr_data = 8'h22;
    @(negedge clk);
    wr_data = 8'h33;
    fork
      check_frame({1'b1, 8'h11, 1'b0}, 1, "dis f1");
      begin
        @(negedge clk);
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        tx_en = 1'b0;
      end
    join
    check("dis level", 32'(level), 32'd2);
    check("dis empty", 32'(empty), 32'd0);
    hold_idle(10, "dis");

    do_reset();
    check("rst2 level", 32'(level), 32'd0);

    // Reset in the middle of DATA with three bytes queued
    baud_div = 16'd2;
    tx_en    = 1'b1;
    wr_data  = 8'h44;
    wr_en    = 1'b1;
    @(negedge clk);
    wr_data = 8'h55;
    @(negedge clk);
    check("midrst start bit", 32'(txd), 32'd0);
    wr_data = 8'h66;
    @(negedge clk);
    wr_data = 8'h77;
    @(negedge clk);
    wr_en = 1'b0;
    check("midrst level before", 32'(level), 32'd3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst txd",   32'(txd),   32'd1);
    check("midrst busy",  32'(busy),  32'd0);
    check("midrst level", 32'(level), 32'd0);
    check("midrst empty", 32'(empty), 32'd1);
    check("midrst full",  32'(full),  32'd0);
    hold_idle(30, "midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
